q_8_9_datapath: RTL

- Register-transfer datapath for the Fig 8.11 ASM. It sits directly downstream of the q_8_9 controller.
- It consumes the controller's control strobes: clr_A_F, incr_A, clr_E, set_E, set_F.
- It holds counter A and flip-flops E and F.
- It returns the status bits A3 and A2 to the controller, closing the control/datapath loop.
- Adds sticky diagnostics (wrap, err), a done pulse and an increment counter for bench observability.

---
 rtl/q_8_9_datapath.sv | 134 +++++++++++++
 1 files changed

// File: rtl/q_8_9_datapath.sv
// Datapath for the Fig 8.11 ASM: counter A, flip-flops E and F, status taps
// back to the controller, plus sticky diagnostics and a saturating increment count.
module q_8_9_datapath #(
    parameter int WIDTH  = 4,
    parameter int TAP_HI = 3,
    parameter int TAP_LO = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_A_F,
    input  logic             incr_A,
    input  logic             clr_E,
    input  logic             set_E,
    input  logic             set_F,
    output logic             A3,
    output logic             A2,
    output logic [WIDTH-1:0] A,
    output logic             E,
    output logic             F,
    output logic             done,
    output logic             wrap,
    output logic             err,
    output logic [CNT_W-1:0] inc_cnt
);

    localparam logic [WIDTH-1:0] A_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] A_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] A_ONES  = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] C_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONES  = {CNT_W{1'b1}};

    logic [WIDTH-1:0] a_r;
    logic [CNT_W-1:0] inc_cnt_r;
    logic             e_r;
    logic             f_r;
    logic             f_dly_r;
    logic             done_r;
    logic             wrap_r;
    logic             err_r;

    logic [WIDTH-1:0] a_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             e_next_s;
    logic             f_next_s;
    logic             wrap_next_s;
    logic             err_next_s;

    // Next-state logic for every strobe-driven register; clr_A_F outranks incr_A.
    always_comb begin
        a_next_s    = a_r;
        cnt_next_s  = inc_cnt_r;
        e_next_s    = e_r;
        f_next_s    = f_r;
        wrap_next_s = wrap_r;
        err_next_s  = err_r;

        if (clr_A_F) begin
            a_next_s    = A_ZERO;
            f_next_s    = 1'b0;
            cnt_next_s  = C_ZERO;
            wrap_next_s = 1'b0;
        end else if (incr_A) begin
            a_next_s = a_r + A_ONE;
            if (a_r == A_ONES) begin
                wrap_next_s = 1'b1;
            end else begin
                wrap_next_s = wrap_r;
            end
            if (inc_cnt_r != C_ONES) begin
                cnt_next_s = inc_cnt_r + C_ONE;
            end else begin
                cnt_next_s = inc_cnt_r;
            end
        end else begin
            a_next_s = a_r;
        end

        // Clear wins over set_F; the collision is flagged below.
        if (set_F && !clr_A_F) begin
            f_next_s = 1'b1;
        end else begin
            f_next_s = f_next_s;
        end

        case ({set_E, clr_E})
            2'b10:   e_next_s = 1'b1;
            2'b01:   e_next_s = 1'b0;
            2'b11:   err_next_s = 1'b1;
            default: e_next_s = e_r;
        endcase

        if (set_F && clr_A_F) begin
            err_next_s = 1'b1;
        end else begin
            err_next_s = err_next_s;
        end
    end

    // State registers; done fires the edge after F's 0->1 transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= A_ZERO;
            inc_cnt_r <= C_ZERO;
            e_r       <= 1'b0;
            f_r       <= 1'b0;
            f_dly_r   <= 1'b0;
            done_r    <= 1'b0;
            wrap_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            a_r       <= a_next_s;
            inc_cnt_r <= cnt_next_s;
            e_r       <= e_next_s;
            f_r       <= f_next_s;
            f_dly_r   <= f_r;
            done_r    <= f_r & ~f_dly_r;
            wrap_r    <= wrap_next_s;
            err_r     <= err_next_s;
        end
    end

    assign A3      = a_r[TAP_HI];
    assign A2      = a_r[TAP_LO];
    assign A       = a_r;
    assign E       = e_r;
    assign F       = f_r;
    assign done    = done_r;
    assign wrap    = wrap_r;
    assign err     = err_r;
    assign inc_cnt = inc_cnt_r;

endmodule
